// File: rtl/serial_frame_receiver.sv
// Start-bit-framed serial deserialiser with optional parity, stop-bit check and a
// one-entry valid/ready output register with sticky overrun reporting.
//
// state  | meaning
// IDLE   | waiting for si = 1 start bit
// DATA   | shifting in DATA_BITS payload bits, MSB first
// PARITY | sampling the parity bit (only when PARITY_MODE != 0)
// STOP   | sampling the stop bit; frame completes at this edge
module serial_frame_receiver #(
  parameter int DATA_BITS   = 40,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 si,
  input  logic                 frame_ready,
  input  logic                 clr_overrun,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 stop_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 se_q, se_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
  logic                 load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    par_d   = par_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    se_d    = se_q;
    ovr_d   = ovr_q;
    done    = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (si) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      DATA: begin
        // Shift-left form also covers DATA_BITS = 1 without a zero-width slice.
        sr_d  = (sr_q << 1) | DATA_BITS'(si);
        par_d = par_q ^ si;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = (PARITY_MODE != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        perr_d  = (PARITY_MODE == 1) ? (par_q ^ si) : ~(par_q ^ si);
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    load = done && (!valid_q || frame_ready);

    if (valid_q && frame_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = sr_q;
      pe_d    = perr_q;
      se_d    = si;
    end

    // A dropped frame outranks a simultaneous clear.
    if (clr_overrun)    ovr_d = 1'b0;
    if (done && !load)  ovr_d = 1'b1;
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign parity_err  = pe_q;
  assign stop_err    = se_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule
